// File: rtl/morph_pkg.sv
// Shared definitions for the 3x3 morphology filter: mode encodings,
// border neutral value and 3-input min/max helpers.
package morph_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam int PIX_MAX_W = 32;
  typedef logic [PIX_MAX_W-1:0] pix_t;

  // Value that cannot influence the reduction: all-ones for min, zero otherwise.
  function automatic pix_t neutral(input mode_e m, input int unsigned w);
    return (m == MODE_ERODE) ? ((~pix_t'(0)) >> (PIX_MAX_W - w)) : pix_t'(0);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    pix_t t;
    t = (a < b) ? a : b;
    return (t < c) ? t : c;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t t;
    t = (a > b) ? a : b;
    return (t > c) ? t : c;
  endfunction

endpackage

// File: rtl/morph_linebuf.sv
// Two cascaded line delays of DEPTH pixels; tap1 is one line back, tap2 two lines back.
module morph_linebuf #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 10
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic [PW-1:0]     ptr;

  assign tap1 = mem1[ptr];
  assign tap2 = mem2[ptr];

  // Read-before-write on a shared pointer gives an exact DEPTH-pixel delay per line.
  always_ff @(posedge CLOCK) begin
    if (en) begin
      mem1[ptr] <= din;
      mem2[ptr] <= tap1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/morph3x3_filter.sv
// 3x3 erode/dilate/bypass filter on a raster pixel stream, two-stage
// reduction pipeline with border substitution by the neutral value.
module morph3x3_filter
  import morph_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              iSOF,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oDATA
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  mode_e             mode_q;
  logic [DATA_W-1:0] tap1, tap2;

  logic [DATA_W-1:0] win_c0 [3];
  logic [DATA_W-1:0] win_c1 [3];
  logic [DATA_W-1:0] win_c2 [3];

  logic [CW-1:0]     in_col;
  logic [RW-1:0]     in_row;
  mode_e             eff_mode;
  logic [DATA_W-1:0] nv_p0;
  logic              top_b, left_b, right_b, pre_b;
  logic [DATA_W-1:0] colr_p0 [3];
  logic [DATA_W-1:0] ctr_p0;

  logic [DATA_W-1:0] colr_p1 [3];
  logic [DATA_W-1:0] ctr_p1;
  mode_e             mode_p1;
  logic              vld_p1;
  logic              vld_p2;

  function automatic logic [DATA_W-1:0] reduce3(input mode_e m,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    case (m)
      MODE_ERODE:  return DATA_W'(min3(pix_t'(a), pix_t'(b), pix_t'(c)));
      MODE_DILATE: return DATA_W'(max3(pix_t'(a), pix_t'(b), pix_t'(c)));
      default:     return b;
    endcase
  endfunction

  morph_linebuf #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .en      (iDVAL),
    .din     (iDATA),
    .tap1    (tap1),
    .tap2    (tap2)
  );

  // Position of the incoming pixel; the centre lies IMG_W+1 pixels behind it.
  assign in_col   = iSOF ? '0 : col_cnt;
  assign in_row   = iSOF ? '0 : row_cnt;
  assign eff_mode = iSOF ? mode_e'(iMODE) : mode_q;

  assign pre_b   = (in_row == '0) || ((in_row == RW'(1)) && (in_col == '0));
  assign top_b   = ((in_row == RW'(1)) && (in_col != '0)) ||
                   ((in_row == RW'(2)) && (in_col == '0));
  assign left_b  = (in_col == CW'(1));
  assign right_b = (in_col == '0);
  assign nv_p0   = DATA_W'(neutral(eff_mode, DATA_W));

  assign win_c2[0] = tap2;
  assign win_c2[1] = tap1;
  assign win_c2[2] = iDATA;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      col_cnt <= '0;
      row_cnt <= '0;
      mode_q  <= MODE_BYPASS;
    end else if (iDVAL) begin
      if (iSOF) mode_q <= mode_e'(iMODE);
      if (in_col == CW'(IMG_W - 1)) begin
        col_cnt <= '0;
        row_cnt <= (in_row == RW'(IMG_H - 1)) ? in_row : in_row + 1'b1;
      end else begin
        col_cnt <= in_col + 1'b1;
        row_cnt <= in_row;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (iDVAL) begin
      win_c0 <= win_c1;
      win_c1 <= win_c2;
    end
  end

  // Stage 0: border substitution and per-column reduction
  always_comb begin
    logic [DATA_W-1:0] t [3];
    for (int k = 0; k < 3; k++) begin
      logic side;
      side = ((k == 0) && left_b) || ((k == 2) && right_b);
      for (int r = 0; r < 3; r++) begin
        case (k)
          0:       t[r] = win_c0[r];
          1:       t[r] = win_c1[r];
          default: t[r] = win_c2[r];
        endcase
        if (side || ((r == 0) && top_b)) t[r] = nv_p0;
      end
      colr_p0[k] = reduce3(eff_mode, t[0], t[1], t[2]);
      if (pre_b) colr_p0[k] = nv_p0;
    end
    ctr_p0 = pre_b ? nv_p0 : win_c1[1];
  end

  // Stage 1: column results registered
  always_ff @(posedge CLOCK) begin
    if (iDVAL) begin
      colr_p1 <= colr_p0;
      ctr_p1  <= ctr_p0;
      mode_p1 <= eff_mode;
    end
  end

  // Stage 2: reduction across columns
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      oDATA  <= '0;
    end else begin
      vld_p1 <= iDVAL;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        if (mode_p1 == MODE_ERODE || mode_p1 == MODE_DILATE)
          oDATA <= reduce3(mode_p1, colr_p1[0], colr_p1[1], colr_p1[2]);
        else
          oDATA <= ctr_p1;
      end
    end
  end

  assign oDVAL = vld_p2;

endmodule

// File: tb/tb_morph3x3_filter.sv
// Scoreboard bench for morph3x3_filter on an 8x4 image.
module tb_morph3x3_filter;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       iSOF = 1'b0;
  logic       iDVAL = 1'b0;
  logic [1:0] iMODE = 2'b00;
  logic [9:0] iDATA = '0;
  logic       oDVAL;
  logic [9:0] oDATA;

  typedef struct {
    logic [9:0] v;
    int         idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] img [N];
  int         checks = 0;
  int         errors = 0;
  logic       h1 = 1'b0, h2 = 1'b0;

  morph3x3_filter #(.DATA_W(10), .IMG_W(W), .IMG_H(H)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .iSOF    (iSOF),
    .iDVAL   (iDVAL),
    .iMODE   (iMODE),
    .iDATA   (iDATA),
    .oDVAL   (oDVAL),
    .oDATA   (oDATA)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference: direct 2-D 3x3 neighbourhood on the stored image.
  function automatic logic [9:0] model(input int mode, input int n);
    int m, r, c, rr, cc;
    logic [9:0] nv, acc, v;
    nv = (mode == 1) ? 10'h3FF : 10'h000;
    if (n < W + 1) return nv;
    m = n - (W + 1);
    r = m / W;
    c = m % W;
    if (mode != 1 && mode != 2) return img[m];
    acc = nv;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        v = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? img[rr*W+cc] : nv;
        if (mode == 1) acc = (v < acc) ? v : acc;
        else           acc = (v > acc) ? v : acc;
      end
    return acc;
  endfunction

  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      checks++;
      if (oDVAL !== h2) begin
        errors++;
        $display("FAIL dval_delay t=%0t got %0b expected %0b", $time, oDVAL, h2);
      end
      if (oDVAL === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %0d expected no output", oDATA);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (oDATA !== e.v) begin
            errors++;
            $display("FAIL pixel_%0d got %0d expected %0d", e.idx, oDATA, e.v);
          end
        end
      end
      h2 = h1;
      h1 = iDVAL;
    end
  end

  task automatic idle_cycle();
    @(posedge CLOCK);
    #1;
    iDVAL = 1'b0;
    iSOF  = 1'($urandom_range(0, 1));
    iMODE = 2'($urandom_range(0, 3));
    iDATA = 10'($urandom_range(0, 1023));
  endtask

  task automatic run_frame(input int fmode, input int later_mode, input int change_at,
                           input bit gaps, input int abort_at);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      @(posedge CLOCK);
      #1;
      if (n == abort_at) begin
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        #1;
        RESET_N = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (oDVAL !== 1'b0) begin
          errors++;
          $display("FAIL async_reset_dval got %0b expected 0", oDVAL);
        end
        checks++;
        if (oDATA !== 10'd0) begin
          errors++;
          $display("FAIL async_reset_data got %0d expected 0", oDATA);
        end
        repeat (3) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        return;
      end
      iDVAL = 1'b1;
      iSOF  = (n == 0);
      iMODE = 2'((n >= change_at) ? later_mode : fmode);
      iDATA = img[n];
      e.v   = model(fmode, n);
      e.idx = n;
      exp_q.push_back(e);
      if (gaps) idle_cycle();
    end
  endtask

  task automatic drain();
    int budget;
    @(posedge CLOCK);
    #1;
    iDVAL = 1'b0;
    iSOF  = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(posedge CLOCK);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge CLOCK);
    #1;
    checks++;
    if (oDVAL !== 1'b0) begin
      errors++;
      $display("FAIL reset_dval got %0b expected 0", oDVAL);
    end
    checks++;
    if (oDATA !== 10'd0) begin
      errors++;
      $display("FAIL reset_data got %0d expected 0", oDATA);
    end
    RESET_N = 1'b1;

    // Erode: single dark pixel at (1,3)
    for (int i = 0; i < N; i++) img[i] = 10'd1023;
    img[1*W+3] = 10'd0;
    run_frame(1, 1, N, 1'b0, -1);

    // Dilate: single bright pixel at (2,0)
    for (int i = 0; i < N; i++) img[i] = 10'd0;
    img[2*W+0] = 10'd1023;
    run_frame(2, 2, N, 1'b0, -1);

    // Bypass ramp, gapless and with iDVAL toggling
    for (int i = 0; i < N; i++) img[i] = 10'(i);
    run_frame(0, 0, N, 1'b0, -1);
    run_frame(0, 0, N, 1'b1, -1);

    // Mode change mid-frame takes effect only on the next frame
    for (int i = 0; i < N; i++) img[i] = 10'((i * 37 + 5) % 1024);
    run_frame(1, 2, 16, 1'b0, -1);
    run_frame(2, 2, N, 1'b1, -1);

    // Reserved mode behaves as bypass
    for (int i = 0; i < N; i++) img[i] = 10'(i);
    run_frame(3, 3, N, 1'b0, -1);
    drain();

    // Reset mid-frame, then a clean bypass frame
    run_frame(0, 0, N, 1'b0, 13);
    run_frame(0, 0, N, 1'b0, -1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
